// File: rtl/write_c_mul_acc.sv
// Pipelined multiplier (operand reg, multiply reg, retiming regs) with per-beat valid tags.
// Define WRITE_C_MUL_ACC_ACCUM_EN to turn the final stage into a wrapping accumulator.
module write_c_mul_acc #(
  parameter int A_WIDTH   = 14,
  parameter int B_WIDTH   = 28,
  parameter int A_SIGNED  = 0,
  parameter int B_SIGNED  = 1,
  parameter int P_WIDTH   = 32,
  parameter int NUM_STAGE = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               in_valid,
  input  logic [A_WIDTH-1:0] din0,
  input  logic [B_WIDTH-1:0] din1,
  input  logic               acc_clr,
  output logic               out_valid,
  output logic [P_WIDTH-1:0] dout
);

  localparam int PW = A_WIDTH + B_WIDTH + 2;

  logic [A_WIDTH:0]      a_q, a_d;
  logic [B_WIDTH:0]      b_q, b_d;
  logic [NUM_STAGE-1:0]  vld_q, vld_d;
  logic [NUM_STAGE-1:0]  clr_q, clr_d;
  logic [P_WIDTH-1:0]    dout_q, dout_d;
  logic signed [PW-1:0]  a_w, b_w, prod_full;
  logic [P_WIDTH-1:0]    prod_p;
  logic [P_WIDTH-1:0]    final_in;
  logic                  a_msb, b_msb;
  logic                  unused_clr_tail;

  assign a_msb = (A_SIGNED != 0) ? din0[A_WIDTH-1] : 1'b0;
  assign b_msb = (B_SIGNED != 0) ? din1[B_WIDTH-1] : 1'b0;

  // Stage 1 operand capture and the valid/clear tag shift register.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    vld_d = vld_q;
    clr_d = clr_q;
    if (ce) begin
      a_d   = {a_msb, din0};
      b_d   = {b_msb, din1};
      vld_d = {vld_q[NUM_STAGE-2:0], in_valid};
      clr_d = {clr_q[NUM_STAGE-2:0], acc_clr};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= '0;
      clr_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      vld_q <= vld_d;
      clr_q <= clr_d;
    end
  end

  // Operands already carry their sign bit, so a signed multiply covers all sign modes.
  assign a_w       = PW'($signed(a_q));
  assign b_w       = PW'($signed(b_q));
  assign prod_full = a_w * b_w;

  generate
    if (P_WIDTH <= PW) begin : g_trunc
      logic unused_prod_hi;
      if (P_WIDTH < PW) begin : g_hi
        assign unused_prod_hi = ^prod_full[PW-1:P_WIDTH];
      end else begin : g_nohi
        assign unused_prod_hi = 1'b0;
      end
      assign prod_p = prod_full[P_WIDTH-1:0];
    end else begin : g_sext
      assign prod_p = {{(P_WIDTH-PW){prod_full[PW-1]}}, prod_full};
    end
  endgenerate

  // The first of these registers is the multiply stage; the rest only retime.
  generate
    if (NUM_STAGE > 2) begin : g_ret
      logic [P_WIDTH-1:0] ret_q [NUM_STAGE-2];
      logic [P_WIDTH-1:0] ret_d [NUM_STAGE-2];

      always_comb begin
        ret_d = ret_q;
        if (ce) begin
          ret_d[0] = prod_p;
          for (int i = 1; i < NUM_STAGE - 2; i++) begin
            ret_d[i] = ret_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < NUM_STAGE - 2; i++) begin
            ret_q[i] <= '0;
          end
        end else begin
          ret_q <= ret_d;
        end
      end

      assign final_in = ret_q[NUM_STAGE-3];
    end else begin : g_noret
      assign final_in = prod_p;
    end
  endgenerate

  // dout only moves when a valid beat enters the last stage, so it holds between beats.
  always_comb begin
    dout_d = dout_q;
    if (ce && vld_q[NUM_STAGE-2]) begin
`ifdef WRITE_C_MUL_ACC_ACCUM_EN
      dout_d = clr_q[NUM_STAGE-2] ? final_in : final_in + dout_q;
`else
      dout_d = final_in;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign unused_clr_tail = clr_q[NUM_STAGE-1];
  assign out_valid       = vld_q[NUM_STAGE-1];
  assign dout            = dout_q;

endmodule

// File: tb/tb_write_c_mul_acc.sv
// Directed self-checking bench for write_c_mul_acc at default parameters.
// Accumulate expectations follow WRITE_C_MUL_ACC_ACCUM_EN when it is defined.
module tb_write_c_mul_acc;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic [13:0] din0;
  logic [27:0] din1;
  logic        acc_clr;
  logic        out_valid;
  logic [31:0] dout;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  write_c_mul_acc #(
    .A_WIDTH  (14),
    .B_WIDTH  (28),
    .A_SIGNED (0),
    .B_SIGNED (1),
    .P_WIDTH  (32),
    .NUM_STAGE(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .in_valid (in_valid),
    .din0     (din0),
    .din1     (din1),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .dout     (dout)
  );

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [13:0] a,
                               input logic [27:0] b, input logic c);
    in_valid = v;
    din0     = a;
    din1     = b;
    acc_clr  = c;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One beat launched on edge 1; result must show on edge 4 and then hold.
  task automatic singleBeat(input string tag, input logic [13:0] a,
                            input logic [27:0] b, input logic [31:0] expected);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(k == 1, a, b, 1'b0);
      tick();
      checkOutput({tag, "_vld"}, 64'(out_valid), 64'(k == 4));
      if (k >= 4) checkOutput({tag, "_dout"}, 64'(dout), 64'(expected));
    end
  endtask

  initial begin
    logic [31:0] acc_exp [3];
    reset = 1'b1;
    ce    = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    checkOutput("rst_vld", 64'(out_valid), 64'd0);
    checkOutput("rst_dout", 64'(dout), 64'd0);

    // Beat on the very first enabled cycle after reset.
    reset = 1'b0;
    ce    = 1'b1;
    singleBeat("mul_neg", 14'd3, 28'hFFFFFFB, 32'hFFFFFFF1);
    singleBeat("wrap", 14'h3FFF, 28'h7FFFFFF, 32'hF7FFC001);

    // Stall for three edges in flight: result on edge 7, dout frozen until then.
    for (int k = 1; k <= 7; k++) begin
      ce = !(k >= 3 && k <= 5);
      applyStimulus(k == 1, 14'd7, 28'd9, 1'b0);
      tick();
      checkOutput("stall_vld", 64'(out_valid), 64'(k == 7));
      checkOutput("stall_dout", 64'(dout), (k == 7) ? 64'd63 : 64'hF7FFC001);
    end
    ce = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput("hold_vld", 64'(out_valid), 64'd1);
      checkOutput("hold_dout", 64'(dout), 64'd63);
    end
    ce = 1'b1;
    tick();
    checkOutput("resume_vld", 64'(out_valid), 64'd0);
    checkOutput("resume_dout", 64'(dout), 64'd63);
    tick();
    tick();

    // Ten back-to-back beats i*2.
    for (int k = 1; k <= 14; k++) begin
      applyStimulus(k <= 10, 14'(k - 1), 28'd2, 1'b0);
      tick();
      checkOutput("stream_vld", 64'(out_valid), 64'(k >= 4 && k <= 13));
      if (k >= 4 && k <= 13) checkOutput("stream_dout", 64'(dout), 64'(2 * (k - 4)));
    end

    // Three beats with reset on the third edge: none may emerge.
    for (int k = 1; k <= 3; k++) begin
      reset = (k == 3);
      applyStimulus(1'b1, 14'd5, 28'd5, 1'b0);
      tick();
    end
    reset = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("flush_rst_dout", 64'(dout), 64'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("flush_vld", 64'(out_valid), 64'd0);
      checkOutput("flush_dout", 64'(dout), 64'd0);
    end
    singleBeat("post_rst", 14'd2, 28'd3, 32'd6);

    // acc_clr only matters in accumulate builds.
`ifdef WRITE_C_MUL_ACC_ACCUM_EN
    acc_exp = '{32'd6, 32'd26, 32'd1};
`else
    acc_exp = '{32'd6, 32'd20, 32'd1};
`endif
    for (int k = 1; k <= 7; k++) begin
      case (k)
        1:       applyStimulus(1'b1, 14'd2, 28'd3, 1'b1);
        2:       applyStimulus(1'b1, 14'd4, 28'd5, 1'b0);
        3:       applyStimulus(1'b1, 14'd1, 28'd1, 1'b1);
        default: applyStimulus(1'b0, '0, '0, 1'b0);
      endcase
      tick();
      checkOutput("acc_vld", 64'(out_valid), 64'(k >= 4 && k <= 6));
      if (k >= 4 && k <= 6) checkOutput("acc_dout", 64'(dout), 64'(acc_exp[k-4]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
